conv_skew_feeder: RTL and testbench
===================================

// Module: conv_skew_feeder
// PURPOSE
//   Upstream feeder for the convfixew systolic conv stage. Accepts one 3x3 feature
//   window (9 signed words) over a valid/ready handshake and replays it as the
//   diagonally skewed lane stream F1..F9 the array consumes. Lane k carries its word
//   for HOLD cycles starting k cycles into the frame and is zero otherwise.
//   Frame markers tell downstream logic when a window has entered the array.
// PARAMETERS
//   N     32  data word width (signed two's complement), matches convfixew N
//   HOLD  4   cycles each lane holds its word (legal 1..8)
//   GAP   3   zero-output flush cycles after each frame (legal 0..15)
// PORTS
//   Clk          in   1     system clock, rising edge
//   Rst_n        in   1     asynchronous active-low reset
//   Sclr         in   1     synchronous clear, active high
//   in_valid     in   1     in_win holds a valid window
//   in_ready     out  1     feeder can accept a window this cycle
//   in_win       in   9*N   window; lane k (1..9) = in_win[N*k-1 -: N]
//   F1..F9       out  N     skewed lane outputs to convfixew F1..F9 (registered)
//   busy         out  1     frame or gap in progress
//   frame_start  out  1     one-cycle pulse in frame cycle 0
//   frame_done   out  1     one-cycle pulse in last frame cycle
// BEHAVIOUR
//   - FRAME = 9 + HOLD cycles (13 at defaults); frame cycles numbered c = 0..FRAME-1.
//   - States: IDLE -> RUN (FRAME cycles) -> GAP (GAP cycles) -> IDLE. If GAP=0,
//     RUN -> IDLE directly.
//   - Reset (Rst_n=0, async): state IDLE, F1..F9=0, busy=0, in_ready=1,
//     frame_start=0, frame_done=0, window register=0, counter=0.
//   - Sclr=1 at a rising edge: same end state as reset, synchronously. Rst_n
//     dominates Sclr. Sclr dominates acceptance in the same cycle.
//   - in_ready=1 only in IDLE (combinational from state). Accept = in_valid &&
//     in_ready at a rising edge. in_win is captured into an internal register at
//     that edge.
//   - The clock period following the accepting edge is frame cycle 0.
//   - In frame cycle c, Fk = win[k] iff k <= c <= k+HOLD-1, else 0. Frame cycle 0 is
//     all-zero.
//   - Outputs are driven from registers; there is no combinational in_win -> Fk path.
//   - in_win/in_valid changes after acceptance have no effect on the current frame.
//   - No buffering: in_valid while not in IDLE is ignored. The source holds the
//     window until accepted.
//   - busy=1 throughout RUN and GAP.
//   - frame_start=1 in c=0 only. frame_done=1 in c=FRAME-1 only.
//   - GAP cycles: all Fk=0. in_ready rises in the first IDLE cycle after GAP.
//     Minimum accept-to-accept spacing = FRAME+GAP+1 cycles (17 at defaults).
//   - Pure data movement: no arithmetic or truncation. Words pass bit-exact,
//     including sign.
//   - Reset mid-frame: outputs go to 0 immediately; the partial window is discarded
//     and not resumed.
// TESTING
//   1. Rst_n=0 for 2 cycles -> all Fk=0, busy=0, in_ready=1, pulses 0. After
//      release, still idle with in_valid=0.
//   2. One window, all lanes=5, defaults:
//      - F1=5 in c1..c4; F9=5 in c9..c12; frame_start at c0; frame_done at c12.
//      - in_ready=1 again 4 cycles after c12 (3 gap cycles + 1).
//   3. Lane k = k, check c5 -> F2..F5 = 2,3,4,5; F1 and F6..F9 = 0. At c1, only F1=1.
//   4. in_valid held high, windows i=1..25 (all lanes = i), in_win changed mid-frame
//      -> one accept every 17 cycles. Each frame carries only its captured value.
//   5. Rst_n low at c6 -> Fk=0 asynchronously, in_ready=1 after release, next
//      window's frame is clean. Repeat with Sclr=1 at c6 -> zeros from the next edge.
//   6. Lanes = -3 (0xFFFFFFFD) -> identical bits on each Fk. Also HOLD=1, GAP=0:
//      FRAME=10, each lane active one cycle, back-to-back accepts every 11 cycles.

Source files
------------

// File: rtl/conv_skew_feeder.sv
// conv_skew_feeder: captures one 3x3 window and replays it as the diagonally
// skewed lane stream F1..F9, followed by a zero-output flush gap.
module conv_skew_feeder #(
    parameter int N    = 32,
    parameter int HOLD = 4,
    parameter int GAP  = 3
) (
    input  logic           Clk,
    input  logic           Rst_n,
    input  logic           Sclr,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [9*N-1:0] in_win,
    output logic [N-1:0]   F1,
    output logic [N-1:0]   F2,
    output logic [N-1:0]   F3,
    output logic [N-1:0]   F4,
    output logic [N-1:0]   F5,
    output logic [N-1:0]   F6,
    output logic [N-1:0]   F7,
    output logic [N-1:0]   F8,
    output logic [N-1:0]   F9,
    output logic           busy,
    output logic           frame_start,
    output logic           frame_done
);
    localparam int FRAME = 9 + HOLD;
    localparam int CW    = 5;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [9*N-1:0]     win_q, win_d;
    logic [8:0][N-1:0]  f_q, f_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        unique case (state_q)
            S_IDLE: if (in_valid) begin
                state_d = S_RUN;
                cnt_d   = '0;
                win_d   = in_win;
            end
            S_RUN: if (cnt_q == CW'(FRAME - 1)) begin
                state_d = (GAP == 0) ? S_IDLE : S_GAP;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            S_GAP: if (cnt_q == CW'(GAP - 1)) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        if (Sclr) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            win_d   = '0;
        end
        // Lanes are computed for the upcoming frame cycle so they leave registered.
        for (int k = 0; k < 9; k++)
            f_d[k] = (state_d == S_RUN && cnt_d >= CW'(k + 1) && cnt_d <= CW'(k + HOLD))
                     ? win_q[N*(k+1)-1 -: N] : '0;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            win_q   <= '0;
            f_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            f_q     <= f_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign frame_start = (state_q == S_RUN) && (cnt_q == '0);
    assign frame_done  = (state_q == S_RUN) && (cnt_q == CW'(FRAME - 1));

    assign F1 = f_q[0];
    assign F2 = f_q[1];
    assign F3 = f_q[2];
    assign F4 = f_q[3];
    assign F5 = f_q[4];
    assign F6 = f_q[5];
    assign F7 = f_q[6];
    assign F8 = f_q[7];
    assign F9 = f_q[8];
endmodule

// File: tb/tb_conv_skew_feeder.sv
// tb_conv_skew_feeder: drives two feeders (HOLD=4/GAP=3 and HOLD=1/GAP=0) and
// checks every frame cycle against a lane-window reference model.
module tb_conv_skew_feeder;
    localparam int N = 32;

    logic Clk = 1'b0, Rst_n = 1'b0, Sclr = 1'b0;
    logic vld_a = 1'b0, vld_b = 1'b0;
    logic [9*N-1:0] win_a = '0, win_b = '0;
    wire rdy_a, rdy_b, busy_a, busy_b, fs_a, fs_b, fd_a, fd_b;
    wire [N-1:0] fa [1:9];
    wire [N-1:0] fb [1:9];
    logic [N-1:0] wm [1:9];
    int n_checks = 0, n_fail = 0, cyc = 0;
    int t0, tp;

    conv_skew_feeder #(.N(N), .HOLD(4), .GAP(3)) dut_a (
        .Clk(Clk), .Rst_n(Rst_n), .Sclr(Sclr), .in_valid(vld_a), .in_ready(rdy_a),
        .in_win(win_a), .F1(fa[1]), .F2(fa[2]), .F3(fa[3]), .F4(fa[4]), .F5(fa[5]),
        .F6(fa[6]), .F7(fa[7]), .F8(fa[8]), .F9(fa[9]), .busy(busy_a),
        .frame_start(fs_a), .frame_done(fd_a)
    );

    conv_skew_feeder #(.N(N), .HOLD(1), .GAP(0)) dut_b (
        .Clk(Clk), .Rst_n(Rst_n), .Sclr(Sclr), .in_valid(vld_b), .in_ready(rdy_b),
        .in_win(win_b), .F1(fb[1]), .F2(fb[2]), .F3(fb[3]), .F4(fb[4]), .F5(fb[5]),
        .F6(fb[6]), .F7(fb[7]), .F8(fb[8]), .F9(fb[9]), .busy(busy_b),
        .frame_start(fs_b), .frame_done(fd_b)
    );

    initial forever #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] lane(input bit d, input int k);
        return d ? fb[k] : fa[k];
    endfunction

    function automatic logic [3:0] status(input bit d);
        return d ? {rdy_b, busy_b, fs_b, fd_b} : {rdy_a, busy_a, fs_a, fd_a};
    endfunction

    function automatic logic rdy(input bit d);
        return d ? rdy_b : rdy_a;
    endfunction

    task automatic set_valid(input bit d, input logic v);
        if (d) vld_b = v; else vld_a = v;
    endtask

    task automatic set_win(input bit d, input logic [9*N-1:0] w);
        if (d) win_b = w; else win_a = w;
    endtask

    task automatic fill(input int mode, input int val);
        for (int k = 1; k <= 9; k++)
            wm[k] = (mode == 0) ? N'(val) : (mode == 1) ? N'(k) : N'($urandom);
    endtask

    task automatic check_idle(input bit d, input string tag);
        chk({tag, "_status"}, 32'(status(d)), 32'(4'b1000));
        for (int k = 1; k <= 9; k++) chk($sformatf("%s_F%0d", tag, k), lane(d, k), '0);
    endtask

    task automatic present(input bit d);
        logic [9*N-1:0] pk;
        int waited;
        waited = 0;
        for (int k = 1; k <= 9; k++) pk[N*k-1 -: N] = wm[k];
        set_win(d, pk);
        set_valid(d, 1'b1);
        while (!rdy(d) && waited < 64) begin
            @(negedge Clk);
            waited++;
        end
        chk("in_ready_before_accept", 32'(rdy(d)), 32'd1);
        @(negedge Clk);
    endtask

    task automatic do_frame(input bit d, input bit keep, input bit scramble, output int ts);
        int hold, gap, frame;
        logic [9*N-1:0] junk;
        hold = d ? 1 : 4;
        gap = d ? 0 : 3;
        frame = 9 + hold;
        present(d);
        ts = cyc;
        if (!keep) set_valid(d, 1'b0);
        for (int c = 0; c < frame; c++) begin
            for (int k = 1; k <= 9; k++)
                chk($sformatf("d%0d_c%0d_F%0d", d, c, k), lane(d, k),
                    (c >= k && c < k + hold) ? wm[k] : '0);
            chk($sformatf("d%0d_c%0d_status", d, c), 32'(status(d)),
                32'({1'b0, 1'b1, c == 0, c == frame - 1}));
            if (scramble) begin
                for (int k = 1; k <= 9; k++) junk[N*k-1 -: N] = $urandom;
                set_win(d, junk);
            end
            @(negedge Clk);
        end
        for (int g = 0; g < gap; g++) begin
            for (int k = 1; k <= 9; k++) chk($sformatf("d%0d_gap%0d_F%0d", d, g, k), lane(d, k), '0);
            chk($sformatf("d%0d_gap%0d_status", d, g), 32'(status(d)), 32'(4'b0100));
            @(negedge Clk);
        end
        chk($sformatf("d%0d_post_status", d), 32'(status(d)), 32'(4'b1000));
    endtask

    initial begin
        // 1: reset
        @(negedge Clk);
        check_idle(0, "rst_a");
        check_idle(1, "rst_b");
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        check_idle(0, "post_rst_a");
        // 2: all lanes 5
        fill(0, 5);
        do_frame(0, 1'b0, 1'b0, t0);
        // 3: lane k = k
        fill(1, 0);
        do_frame(0, 1'b0, 1'b0, t0);
        // 4: 25 windows back to back with in_valid held and in_win scrambled mid-frame
        tp = -1;
        for (int i = 1; i <= 25; i++) begin
            fill(0, i);
            do_frame(0, 1'b1, 1'b1, t0);
            if (tp >= 0) chk($sformatf("spacing_a_%0d", i), 32'(t0 - tp), 32'd17);
            tp = t0;
        end
        set_valid(0, 1'b0);
        @(negedge Clk);
        // 5a: async reset at c6
        fill(2, 0);
        present(0);
        set_valid(0, 1'b0);
        repeat (6) @(negedge Clk);
        chk("c6_F4_before_reset", fa[4], wm[4]);
        Rst_n = 1'b0;
        #1;
        check_idle(0, "async_rst");
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        check_idle(0, "after_async_rst");
        fill(2, 0);
        do_frame(0, 1'b0, 1'b0, t0);
        // 5b: Sclr at c6 takes effect on the next edge only
        fill(2, 0);
        present(0);
        set_valid(0, 1'b0);
        repeat (6) @(negedge Clk);
        Sclr = 1'b1;
        #1;
        chk("sclr_c6_F5_held", fa[5], wm[5]);
        @(negedge Clk);
        Sclr = 1'b0;
        check_idle(0, "after_sclr");
        // Sclr beats a same-cycle accept
        fill(1, 0);
        set_valid(0, 1'b1);
        Sclr = 1'b1;
        @(negedge Clk);
        Sclr = 1'b0;
        set_valid(0, 1'b0);
        check_idle(0, "sclr_vs_accept");
        fill(2, 0);
        do_frame(0, 1'b0, 1'b0, t0);
        // 6: negative words pass bit-exact
        fill(0, -3);
        do_frame(0, 1'b0, 1'b0, t0);
        // 6: HOLD=1, GAP=0 back to back every 11 cycles
        tp = -1;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) fill(0, -3); else fill(2, 0);
            do_frame(1, 1'b1, 1'b1, t0);
            if (tp >= 0) chk($sformatf("spacing_b_%0d", i), 32'(t0 - tp), 32'd11);
            tp = t0;
        end
        set_valid(1, 1'b0);
        @(negedge Clk);
        check_idle(1, "final_b");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
